seq_magnitude_comparator: RTL and testbench



---
 rtl/seq_magnitude_comparator.sv | 102 ++++++++++
 tb/tb_seq_magnitude_comparator.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator.sv
// Chunk-serial magnitude comparator: walks CHUNK bits per clock from the MSB chunk down,
// stopping at the first unequal chunk. Signed mode biases the MSB so an unsigned compare works.
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             A_gt_B,
    output logic             A_lt_B,
    output logic             A_eq_B
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                         r_state, w_next;
    logic [WIDTH-1:0]               r_a, r_b;
    logic                           r_signed;
    logic [IDXW-1:0]                r_idx;
    logic                           r_gt, r_lt, r_eq;

    logic [WIDTH-1:0]               w_sign_mask;
    logic [NCHUNK-1:0][CHUNK-1:0]   w_a_ch, w_b_ch;
    logic [CHUNK-1:0]               w_ca, w_cb;
    logic                           w_ne, w_last;

    // Flipping both MSBs maps two's-complement order onto unsigned order.
    assign w_sign_mask = {r_signed, {(WIDTH-1){1'b0}}};
    assign w_a_ch      = r_a ^ w_sign_mask;
    assign w_b_ch      = r_b ^ w_sign_mask;
    assign w_ca        = w_a_ch[r_idx];
    assign w_cb        = w_b_ch[r_idx];
    assign w_ne        = (w_ca != w_cb);
    assign w_last      = (r_idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_ne || w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_idx    <= '0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_signed <= signed_mode;
                        r_idx    <= IDXW'(NCHUNK - 1);
                    end
                end
                S_RUN: begin
                    if (w_ne) begin
                        r_gt <= (w_ca > w_cb);
                        r_lt <= (w_ca < w_cb);
                        r_eq <= 1'b0;
                    end else if (w_last) begin
                        r_gt <= 1'b0;
                        r_lt <= 1'b0;
                        r_eq <= 1'b1;
                    end else begin
                        r_idx <= r_idx - IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign A_gt_B = r_gt;
    assign A_lt_B = r_lt;
    assign A_eq_B = r_eq;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench: expected results are queued at start; a negedge monitor pops them on done
// and also checks latency, busy length and that results hold between operations.
module tb_seq_magnitude_comparator;
    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    typedef struct {
        logic gt, lt, eq;
        int   k;
        int   dcyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             signed_mode = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             busy, done, A_gt_B, A_lt_B, A_eq_B;

    int   tests = 0, fails = 0;
    int   cyc = 0;
    int   bcnt = 0;
    logic [2:0] last = '0;
    exp_t sb[$];

    seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done),
        .A_gt_B(A_gt_B), .A_lt_B(A_lt_B), .A_eq_B(A_eq_B)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic ts);
        exp_t e;
        logic [WIDTH-1:0] x;
        logic [CHUNK-1:0] c;
        e.gt = ts ? ($signed(ta) > $signed(tb_)) : (ta > tb_);
        e.lt = ts ? ($signed(ta) < $signed(tb_)) : (ta < tb_);
        e.eq = (ta == tb_);
        e.k  = NCHUNK;
        e.dcyc = 0;
        x = ta ^ tb_;
        for (int i = NCHUNK - 1; i >= 0; i--) begin
            c = x[i*CHUNK +: CHUNK];
            if (c != '0) begin
                e.k = NCHUNK - i;
                break;
            end
        end
        return e;
    endfunction

    // Monitor: pops on done, otherwise requires results to stay put.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last = '0;
            bcnt = 0;
        end else begin
            if (busy) bcnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("gt", A_gt_B, e.gt);
                    chk("lt", A_lt_B, e.lt);
                    chk("eq", A_eq_B, e.eq);
                    chk("latency_cyc", cyc, e.dcyc);
                    chk("busy_cycles", bcnt, e.k);
                    chk("busy_in_done", busy, 0);
                end
                last = {A_gt_B, A_lt_B, A_eq_B};
                bcnt = 0;
            end else begin
                chk("hold", {A_gt_B, A_lt_B, A_eq_B}, last);
            end
        end
    end

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
    task automatic op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic ts,
                      input int disturb, input bit start_in_done);
        exp_t e;
        bit got;
        e = model(ta, tb_, ts);
        e.dcyc = cyc + 1 + e.k;
        sb.push_back(e);
        a = ta; b = tb_; signed_mode = ts; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) got = 1'b1;
            else if (disturb == i + 1) begin
                a = '0; b = '1; signed_mode = ~ts; start = 1'b1;
            end
        end
        if (!got) chk("done_timeout", 0, 1);
        if (start_in_done) begin
            a = 16'h0001; b = 16'h0002; start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("start_in_done_ignored", busy, 0);
            end
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", {A_gt_B, A_lt_B, A_eq_B}, 3'b000);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        op(16'h1235, 16'h1234, 1'b0, 0, 1'b0);
        op(16'h1300, 16'h12FF, 1'b0, 0, 1'b0);
        op(16'h0000, 16'h8000, 1'b0, 0, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b1, 0, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        op(16'hFFFE, 16'hFFFF, 1'b1, 0, 1'b0);
        op(16'hA5A5, 16'hA5A5, 1'b0, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("eq_stable", {A_gt_B, A_lt_B, A_eq_B}, 3'b001);
        end
        // Input changes and a start pulse mid-RUN, then start held only during DONE.
        op(16'h1235, 16'h1234, 1'b0, 2, 1'b1);
        op(16'h8000, 16'h7FFF, 1'b1, 0, 1'b0);
        op(16'h7FFF, 16'h8000, 1'b1, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = ra ^ (16'h1 << $urandom_range(0, 15));
            op(ra, (i % 3 == 0) ? ra : rb, 1'($urandom_range(0, 1)), 0, 1'b0);
        end
        op(16'h0001, 16'h0002, 1'b0, 0, 1'b0);

        // Abort an equal compare two edges into RUN.
        a = 16'h5A5A; b = 16'h5A5A; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_res", {A_gt_B, A_lt_B, A_eq_B}, 3'b000);
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        op(16'h4321, 16'h4320, 1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
